alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
// ID/EX pipeline register and operand driver feeding the alu (aluOp, in1, in2).
// Latches decoded instruction fields from ID and applies EX/MEM and MEM/WB forwarding to the operands.
// Detects load-use hazards, stalls IF/ID and inserts a bubble.
// Supports flush (branch taken) and a downstream hold, so the alu always sees a legal op/operand set.
// PARAMETERS
// BITS      32  datapath width of operands/results
// REG_BITS  5   register-index width
// PORTS
// clk             in   1         rising-edge clock
// rst_n           in   1         asynchronous active-low reset
// id_valid        in   1         ID holds a real instruction
// id_aluOp        in   4         decoded `ALU_* opcode
// id_rs, id_rt    in   REG_BITS  source register indices
// id_rsData       in   BITS      register-file read of rs
// id_rtData       in   BITS      register-file read of rt
// id_imm          in   BITS      sign-extended immediate
// id_aluSrc       in   1         1: in2 = imm (rt unused), 0: in2 = rt
// id_rd           in   REG_BITS  destination index
// id_regWrite     in   1         instruction writes rd
// id_memRead      in   1         instruction is a load
// flush           in   1         kill instruction entering EX
// hold            in   1         downstream stall; freeze stage
// exm_regWrite    in   1         EX/MEM writes a register
// exm_rd          in   REG_BITS  EX/MEM destination
// exm_result      in   BITS      EX/MEM alu result
// mwb_regWrite    in   1         MEM/WB writes a register
// mwb_rd          in   REG_BITS  MEM/WB destination
// mwb_result      in   BITS      MEM/WB writeback value
// ex_valid        out  1         EX slot holds a real instruction
// aluOp           out  4         to alu
// in1, in2        out  BITS      to alu, post-forwarding
// ex_rd           out  REG_BITS  EX destination
// ex_regWrite     out  1         EX regWrite (0 when bubble)
// ex_memRead      out  1         EX memRead (0 when bubble)
// stall           out  1         to PC/IF-ID: hold fetch/decode this cycle
// BEHAVIOUR
// - Reset (async, rst_n=0): all registered fields 0; ex_valid=0, aluOp=`ALU_ADD, ex_rd=0, ex_regWrite=0, ex_memRead=0.
//   in1/in2 read 0 (forwarding never hits register 0). stall=0. Reset mid-stall discards the held instruction.
// - Per-edge update, priority highest first:
//   flush > hold > load-use bubble > load.
//   - flush: load a bubble.
//   - hold: keep all registers.
//   - load-use bubble: load a bubble.
//   - load: capture all id_* fields with ex_valid=id_valid.
// - Bubble: ex_valid=0, aluOp=`ALU_ADD, rs=rt=rd=0, data/imm=0, regWrite=0, memRead=0.
// - Load-use hazard (combinational): id_valid & ex_valid & ex_memRead & ex_rd!=0 &
//   (ex_rd==id_rs | (ex_rd==id_rt & !id_aluSrc)).
//   stall = hazard & !flush & !hold. stall asserts for exactly one cycle per hazard;
//   the next cycle EX holds the bubble, so the same ID instruction issues.
// - hold: stall output is 0 (upstream freezes via hold separately); no bubble is inserted.
// - Forwarding (combinational on registered rs/rt, latency 0 to alu):
//   - If exm_regWrite & exm_rd!=0 & exm_rd==src, use exm_result.
//   - Else if mwb_regWrite & mwb_rd!=0 & mwb_rd==src, use mwb_result.
//   - Else use the latched register data. EX/MEM wins when both match.
//   - in1 = fwd(rs). in2 = aluSrc ? imm : fwd(rt).
// - Latency: ID fields appear on outputs 1 cycle after the edge that loads them.
// - Widths: no arithmetic here; all data paths are BITS wide, with no truncation or extension.
// TESTING
// - Reset: rst_n=0 mid-run with ex_valid=1 -> outputs cleared immediately (async), no clk edge needed.
// - Issue: id rs=2 data=5, rt=3 data=10, aluSrc=0, aluOp=`ALU_ADD -> next cycle in1=5, in2=10,
//   aluOp=`ALU_ADD, ex_valid=1.
// - Forwarding: rs=4, exm_rd=4 result=0x11, mwb_rd=4 result=0x22 -> in1=0x11.
//   Deassert exm_regWrite -> in1=0x22. Set rd=0 on both -> raw data.
// - Load-use: EX holds load to r7; ID uses rt=7, aluSrc=0 -> stall=1 one cycle, then a bubble
//   (ex_valid=0, ex_regWrite=0); ID is reissued the following cycle. With aluSrc=1 -> no stall.
// - Flush vs hazard: flush=1 while a hazard is present -> stall=0 and a bubble is loaded.
//   hold=1 -> registers unchanged for 3 cycles, then resume.
// - Self-check: every cycle, compare alu output against a model of the `ALU_ADD/SUB/AND/OR/SLT` operation
//   applied to expected in1/in2.

Source files
------------

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Desc     : ID/EX pipeline register and alu operand driver. Latches decoded
//            fields, forwards EX/MEM and MEM/WB results onto the operands,
//            detects load-use hazards (stall + bubble), honours flush/hold.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int BITS     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [3:0]          id_aluOp,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [BITS-1:0]     id_rsData,
  input  logic [BITS-1:0]     id_rtData,
  input  logic [BITS-1:0]     id_imm,
  input  logic                id_aluSrc,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_regWrite,
  input  logic                id_memRead,
  input  logic                flush,
  input  logic                hold,
  input  logic                exm_regWrite,
  input  logic [REG_BITS-1:0] exm_rd,
  input  logic [BITS-1:0]     exm_result,
  input  logic                mwb_regWrite,
  input  logic [REG_BITS-1:0] mwb_rd,
  input  logic [BITS-1:0]     mwb_result,
  output logic                ex_valid,
  output logic [3:0]          aluOp,
  output logic [BITS-1:0]     in1,
  output logic [BITS-1:0]     in2,
  output logic [REG_BITS-1:0] ex_rd,
  output logic                ex_regWrite,
  output logic                ex_memRead,
  output logic                stall
);

  // Bubble opcode: ADD of zero operands is harmless to the alu.
  localparam logic [3:0] c_ALU_ADD = 4'h0;

  logic                r_valid;
  logic [3:0]          r_aluOp;
  logic [REG_BITS-1:0] r_rs;
  logic [REG_BITS-1:0] r_rt;
  logic [BITS-1:0]     r_rsData;
  logic [BITS-1:0]     r_rtData;
  logic [BITS-1:0]     r_imm;
  logic                r_aluSrc;
  logic [REG_BITS-1:0] r_rd;
  logic                r_regWrite;
  logic                r_memRead;

  logic                w_hazard;
  logic                w_bubble;
  logic [BITS-1:0]     w_fwdRs;
  logic [BITS-1:0]     w_fwdRt;

  // Load-use hazard: a load in EX whose destination feeds the ID instruction.
  // rt only matters when the second operand actually comes from rt.
  always_comb begin
    w_hazard = id_valid && r_valid && r_memRead && (r_rd != '0) &&
               ((r_rd == id_rs) || ((r_rd == id_rt) && !id_aluSrc));
    // Flush and hold both outrank the hazard; neither asks upstream to stall.
    stall    = w_hazard && !flush && !hold;
    w_bubble = flush || (!hold && w_hazard);
  end

  // ID/EX register: flush > hold > load-use bubble > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_aluOp    <= c_ALU_ADD;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rsData   <= '0;
      r_rtData   <= '0;
      r_imm      <= '0;
      r_aluSrc   <= 1'b0;
      r_rd       <= '0;
      r_regWrite <= 1'b0;
      r_memRead  <= 1'b0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_aluOp    <= c_ALU_ADD;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rsData   <= '0;
      r_rtData   <= '0;
      r_imm      <= '0;
      r_aluSrc   <= 1'b0;
      r_rd       <= '0;
      r_regWrite <= 1'b0;
      r_memRead  <= 1'b0;
    end else if (!hold) begin
      r_valid    <= id_valid;
      r_aluOp    <= id_aluOp;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rsData   <= id_rsData;
      r_rtData   <= id_rtData;
      r_imm      <= id_imm;
      r_aluSrc   <= id_aluSrc;
      r_rd       <= id_rd;
      r_regWrite <= id_regWrite;
      r_memRead  <= id_memRead;
    end
  end

  // Operand forwarding: the younger EX/MEM result wins over MEM/WB; r0 never forwards.
  always_comb begin
    w_fwdRs = r_rsData;
    if (exm_regWrite && (exm_rd != '0) && (exm_rd == r_rs))
      w_fwdRs = exm_result;
    else if (mwb_regWrite && (mwb_rd != '0) && (mwb_rd == r_rs))
      w_fwdRs = mwb_result;

    w_fwdRt = r_rtData;
    if (exm_regWrite && (exm_rd != '0) && (exm_rd == r_rt))
      w_fwdRt = exm_result;
    else if (mwb_regWrite && (mwb_rd != '0) && (mwb_rd == r_rt))
      w_fwdRt = mwb_result;
  end

  // Drive the alu and downstream control from the EX slot.
  always_comb begin
    ex_valid    = r_valid;
    aluOp       = r_aluOp;
    in1         = w_fwdRs;
    in2         = r_aluSrc ? r_imm : w_fwdRt;
    ex_rd       = r_rd;
    ex_regWrite = r_regWrite;
    ex_memRead  = r_memRead;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Desc     : Directed testbench for alu_issue_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

  localparam logic [3:0] c_ADD = 4'h0;
  localparam logic [3:0] c_SUB = 4'h1;
  localparam logic [3:0] c_AND = 4'h2;
  localparam logic [3:0] c_OR  = 4'h3;
  localparam logic [3:0] c_SLT = 4'h4;

  logic        clk, rst_n;
  logic        id_valid, id_aluSrc, id_regWrite, id_memRead;
  logic [3:0]  id_aluOp;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rsData, id_rtData, id_imm;
  logic        flush, hold;
  logic        exm_regWrite, mwb_regWrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        ex_valid, ex_regWrite, ex_memRead, stall;
  logic [3:0]  aluOp;
  logic [31:0] in1, in2;
  logic [4:0]  ex_rd;

  int vecs = 0;
  int errs = 0;

  alu_issue_stage #(.BITS(32), .REG_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_aluOp(id_aluOp), .id_rs(id_rs), .id_rt(id_rt),
    .id_rsData(id_rsData), .id_rtData(id_rtData), .id_imm(id_imm),
    .id_aluSrc(id_aluSrc), .id_rd(id_rd), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .flush(flush), .hold(hold),
    .exm_regWrite(exm_regWrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_regWrite(mwb_regWrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .aluOp(aluOp), .in1(in1), .in2(in2), .ex_rd(ex_rd),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference alu used to check what the alu would compute from the driven set.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      c_ADD:   alu_f = a + b;
      c_SUB:   alu_f = a - b;
      c_AND:   alu_f = a & b;
      c_OR:    alu_f = a | b;
      c_SLT:   alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_f = 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_aluOp = c_ADD; id_rs = 0; id_rt = 0; id_rsData = 0; id_rtData = 0;
    id_imm = 0; id_aluSrc = 0; id_rd = 0; id_regWrite = 0; id_memRead = 0;
    flush = 0; hold = 0;
    exm_regWrite = 0; exm_rd = 0; exm_result = 0;
    mwb_regWrite = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  task automatic drive_id(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic src, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = 1; id_aluOp = op; id_rs = rs; id_rt = rt; id_rsData = rsd; id_rtData = rtd;
    id_imm = imm; id_aluSrc = src; id_rd = rd; id_regWrite = rw; id_memRead = mr;
  endtask

  task automatic test_reset();
    vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    vecs++; if (aluOp !== c_ADD) begin errs++; $display("FAIL reset_aluOp got %h want %h", aluOp, c_ADD); end
    vecs++; if ({in1, in2} !== 64'd0) begin errs++; $display("FAIL reset_operands got %h/%h want 0/0", in1, in2); end
    vecs++; if ({ex_rd, ex_regWrite, ex_memRead, stall} !== 8'd0) begin errs++;
      $display("FAIL reset_ctrl got rd=%0d rw=%b mr=%b st=%b want all 0", ex_rd, ex_regWrite, ex_memRead, stall); end
  endtask

  task automatic test_issue();
    drive_id(c_ADD, 5'd2, 5'd3, 32'd5, 32'd10, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    step();
    vecs++; if (ex_valid !== 1'b1) begin errs++; $display("FAIL issue_valid got %b want 1", ex_valid); end
    vecs++; if (aluOp !== c_ADD) begin errs++; $display("FAIL issue_aluOp got %h want %h", aluOp, c_ADD); end
    vecs++; if (in1 !== 32'd5 || in2 !== 32'd10) begin errs++; $display("FAIL issue_ops got %0d/%0d want 5/10", in1, in2); end
    vecs++; if (ex_rd !== 5'd1 || ex_regWrite !== 1'b1 || ex_memRead !== 1'b0) begin errs++;
      $display("FAIL issue_ctrl got rd=%0d rw=%b mr=%b want 1/1/0", ex_rd, ex_regWrite, ex_memRead); end
    vecs++; if (alu_f(aluOp, in1, in2) !== 32'd15) begin errs++; $display("FAIL issue_alu got %0d want 15", alu_f(aluOp, in1, in2)); end
    // Immediate operand replaces rt data.
    drive_id(c_SUB, 5'd2, 5'd3, 32'd7, 32'd99, 32'hFFFF_FFFF, 1'b1, 5'd1, 1'b1, 1'b0);
    step();
    vecs++; if (in2 !== 32'hFFFF_FFFF) begin errs++; $display("FAIL imm_in2 got %h want ffffffff", in2); end
    vecs++; if (alu_f(aluOp, in1, in2) !== 32'd8) begin errs++; $display("FAIL imm_alu got %0d want 8", alu_f(aluOp, in1, in2)); end
  endtask

  task automatic test_forward();
    drive_id(c_OR, 5'd4, 5'd5, 32'h99, 32'h55, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    exm_regWrite = 1; exm_rd = 5'd4; exm_result = 32'h11;
    mwb_regWrite = 1; mwb_rd = 5'd4; mwb_result = 32'h22;
    step();
    vecs++; if (in1 !== 32'h11) begin errs++; $display("FAIL fwd_exm got %h want 11", in1); end
    vecs++; if (in2 !== 32'h55) begin errs++; $display("FAIL fwd_rt_raw got %h want 55", in2); end
    exm_regWrite = 0; #1;
    vecs++; if (in1 !== 32'h22) begin errs++; $display("FAIL fwd_mwb got %h want 22", in1); end
    exm_regWrite = 1; exm_rd = 5'd0; mwb_rd = 5'd0; #1;
    vecs++; if (in1 !== 32'h99) begin errs++; $display("FAIL fwd_r0_raw got %h want 99", in1); end
    mwb_rd = 5'd5; #1;
    vecs++; if (in2 !== 32'h22) begin errs++; $display("FAIL fwd_rt_mwb got %h want 22", in2); end
    vecs++; if (alu_f(aluOp, in1, in2) !== 32'hBB) begin errs++; $display("FAIL fwd_alu got %h want bb", alu_f(aluOp, in1, in2)); end
    exm_regWrite = 0; mwb_regWrite = 0; exm_rd = 0; mwb_rd = 0;
  endtask

  task automatic test_load_use();
    drive_id(c_ADD, 5'd1, 5'd0, 32'd0, 32'd0, 32'h40, 1'b1, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(c_AND, 5'd2, 5'd7, 32'hF0, 32'hFF, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    #1;
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL lu_stall got %b want 1", stall); end
    step();
    vecs++; if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0 || ex_memRead !== 1'b0 || aluOp !== c_ADD) begin errs++;
      $display("FAIL lu_bubble got v=%b rw=%b mr=%b op=%h want 0/0/0/0", ex_valid, ex_regWrite, ex_memRead, aluOp); end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL lu_stall_once got %b want 0", stall); end
    step();
    vecs++; if (ex_valid !== 1'b1 || aluOp !== c_AND || in1 !== 32'hF0 || in2 !== 32'hFF) begin errs++;
      $display("FAIL lu_reissue got v=%b op=%h in1=%h in2=%h want 1/2/f0/ff", ex_valid, aluOp, in1, in2); end
    vecs++; if (alu_f(aluOp, in1, in2) !== 32'hF0) begin errs++; $display("FAIL lu_alu got %h want f0", alu_f(aluOp, in1, in2)); end
    // Immediate form does not read rt, so no hazard.
    drive_id(c_ADD, 5'd1, 5'd0, 32'd0, 32'd0, 32'h40, 1'b1, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(c_ADD, 5'd2, 5'd7, 32'd3, 32'd0, 32'd4, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL lu_imm_nostall got %b want 0", stall); end
    step();
    vecs++; if (ex_valid !== 1'b1 || in2 !== 32'd4) begin errs++; $display("FAIL lu_imm_issue got v=%b in2=%0d want 1/4", ex_valid, in2); end
  endtask

  task automatic test_flush_hazard();
    drive_id(c_ADD, 5'd1, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(c_OR, 5'd7, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    flush = 1; #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL flush_stall got %b want 0", stall); end
    step();
    flush = 0;
    vecs++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_memRead !== 1'b0) begin errs++;
      $display("FAIL flush_bubble got v=%b rd=%0d mr=%b want 0/0/0", ex_valid, ex_rd, ex_memRead); end
    step();
    vecs++; if (ex_valid !== 1'b1 || aluOp !== c_OR || ex_rd !== 5'd9) begin errs++;
      $display("FAIL flush_resume got v=%b op=%h rd=%0d want 1/3/9", ex_valid, aluOp, ex_rd); end
  endtask

  task automatic test_hold();
    // EX holds a load to r7, ID wants r7: hold must freeze without stalling.
    drive_id(c_ADD, 5'd1, 5'd0, 32'h3, 32'd0, 32'h8, 1'b1, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(c_SUB, 5'd7, 5'd2, 32'h100, 32'h1, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL hold_stall[%0d] got %b want 0", i, stall); end
      step();
      vecs++; if (ex_valid !== 1'b1 || ex_memRead !== 1'b1 || ex_rd !== 5'd7 || in1 !== 32'h3 || in2 !== 32'h8) begin errs++;
        $display("FAIL hold_keep[%0d] got v=%b mr=%b rd=%0d in1=%h in2=%h want 1/1/7/3/8", i, ex_valid, ex_memRead, ex_rd, in1, in2); end
    end
    hold = 0; #1;
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL hold_release_stall got %b want 1", stall); end
    step();
    vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL hold_release_bubble got %b want 0", ex_valid); end
    step();
    vecs++; if (ex_valid !== 1'b1 || aluOp !== c_SUB || alu_f(aluOp, in1, in2) !== 32'hFF) begin errs++;
      $display("FAIL hold_resume got v=%b op=%h alu=%h want 1/1/ff", ex_valid, aluOp, alu_f(aluOp, in1, in2)); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [5] = '{c_ADD, c_SUB, c_AND, c_OR, c_SLT};
    logic [31:0] as  [5] = '{32'd100, 32'd3, 32'hF0F0, 32'h0F00, 32'hFFFF_FFFD};
    logic [31:0] bs  [5] = '{32'd23, 32'd5, 32'h3C3C, 32'h00F0, 32'd2};
    logic [31:0] rs  [5] = '{32'd123, 32'hFFFF_FFFE, 32'h3030, 32'h0FF0, 32'd1};
    for (int i = 0; i < 5; i++) begin
      drive_id(ops[i], 5'd11, 5'd12, as[i], bs[i], 32'd0, 1'b0, 5'd13, 1'b1, 1'b0);
      step();
      vecs++; if (ex_valid !== 1'b1 || aluOp !== ops[i] || in1 !== as[i] || in2 !== bs[i]) begin errs++;
        $display("FAIL b2b_ops[%0d] got v=%b op=%h in1=%h in2=%h want 1/%h/%h/%h", i, ex_valid, aluOp, in1, in2, ops[i], as[i], bs[i]); end
      vecs++; if (alu_f(aluOp, in1, in2) !== rs[i]) begin errs++;
        $display("FAIL b2b_alu[%0d] got %h want %h", i, alu_f(aluOp, in1, in2), rs[i]); end
    end
  endtask

  task automatic test_async_reset();
    drive_id(c_OR, 5'd3, 5'd4, 32'h77, 32'h88, 32'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    vecs++; if (ex_valid !== 1'b1) begin errs++; $display("FAIL areset_pre got %b want 1", ex_valid); end
    #2 rst_n = 0; #1;
    vecs++; if (ex_valid !== 1'b0 || aluOp !== c_ADD || in1 !== 32'd0 || in2 !== 32'd0) begin errs++;
      $display("FAIL areset_clear got v=%b op=%h in1=%h in2=%h want 0/0/0/0", ex_valid, aluOp, in1, in2); end
    vecs++; if (ex_rd !== 5'd0 || ex_regWrite !== 1'b0 || ex_memRead !== 1'b0 || stall !== 1'b0) begin errs++;
      $display("FAIL areset_ctrl got rd=%0d rw=%b mr=%b st=%b want 0/0/0/0", ex_rd, ex_regWrite, ex_memRead, stall); end
    step();
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    #12;
    test_reset();
    rst_n = 1;
    step();
    test_issue();
    clear_inputs();
    test_forward();
    clear_inputs();
    step();
    test_load_use();
    clear_inputs();
    step();
    test_flush_hazard();
    clear_inputs();
    step();
    test_hold();
    clear_inputs();
    step();
    test_back_to_back();
    clear_inputs();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
